// File: rtl/sram_mem_ctrl.sv
// PicoRV32 / UART-loader front end for two single-port 32-bit SRAM banks (imem, dmem).
// Optional loader port and CPU/loader arbitration enabled by defining SRAM_CTRL_LOADER_EN.
`timescale 1ns/1ps

module sram_mem_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    mem_valid,
  input  logic                    mem_instr,
  input  logic [31:0]             mem_addr,
  input  logic [DATA_WIDTH-1:0]   mem_wdata,
  input  logic [DATA_WIDTH/8-1:0] mem_wstrb,
  output logic                    mem_ready,
  output logic [DATA_WIDTH-1:0]   mem_rdata,
  input  logic                    ld_valid,
  input  logic                    ld_bank,
  input  logic [ADDR_WIDTH-1:0]   ld_addr,
  input  logic [DATA_WIDTH-1:0]   ld_wdata,
  output logic                    ld_ready,
  output logic                    bus_err,
  output logic                    imem_csb,
  output logic                    imem_web,
  output logic [ADDR_WIDTH-1:0]   imem_addr,
  output logic [DATA_WIDTH-1:0]   imem_din,
  input  logic [DATA_WIDTH-1:0]   imem_dout,
  output logic                    dmem_csb,
  output logic                    dmem_web,
  output logic [ADDR_WIDTH-1:0]   dmem_addr,
  output logic [DATA_WIDTH-1:0]   dmem_din,
  input  logic [DATA_WIDTH-1:0]   dmem_dout
);

  localparam int STRB_W = DATA_WIDTH / 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    RESP    = 2'd2,
    LD_ACK  = 2'd3
  } state_t;

  state_t                  state_q, state_d;
  logic                    mem_ready_q, mem_ready_d;
  logic                    ld_ready_q, ld_ready_d;
  logic [DATA_WIDTH-1:0]   mem_rdata_q, mem_rdata_d;
  logic                    bus_err_q, bus_err_d;
  logic                    last_ld_q, last_ld_d;
  logic                    req_bank_q, req_bank_d;
  logic [ADDR_WIDTH-1:0]   req_word_q, req_word_d;
  logic [STRB_W-1:0]       req_wstrb_q, req_wstrb_d;
  logic [DATA_WIDTH-1:0]   req_wdata_q, req_wdata_d;

  logic                    cpu_bank;
  logic [ADDR_WIDTH-1:0]   cpu_word;
  logic                    cpu_oor;
  logic                    ld_req;
  logic                    serve_ld;
  logic [DATA_WIDTH-1:0]   rd_dout;
  logic [DATA_WIDTH-1:0]   merged_data;

  logic                    cmd_en;
  logic                    cmd_we;
  logic                    cmd_bank;
  logic [ADDR_WIDTH-1:0]   cmd_addr;
  logic [DATA_WIDTH-1:0]   cmd_din;

  assign cpu_bank = mem_addr[ADDR_WIDTH+2];
  assign cpu_word = mem_addr[ADDR_WIDTH+1:2];
  assign cpu_oor  = |mem_addr[31:ADDR_WIDTH+3];

`ifdef SRAM_CTRL_LOADER_EN
  assign ld_req   = ld_valid;
  assign ld_ready = ld_ready_q;
  logic unused_sigs;
  assign unused_sigs = ^{mem_instr, mem_addr[1:0]};
`else
  assign ld_req   = 1'b0;
  assign ld_ready = 1'b0;
  logic unused_sigs;
  assign unused_sigs = ^{mem_instr, mem_addr[1:0], ld_valid, ld_ready_q};
`endif

  // On a tie the loader wins unless it was the one served last.
  assign serve_ld = ld_req && (!mem_valid || !last_ld_q);

  assign rd_dout = req_bank_q ? dmem_dout : imem_dout;

  genvar gi;
  generate
    for (gi = 0; gi < STRB_W; gi++) begin : g_merge
      assign merged_data[gi*8 +: 8] = req_wstrb_q[gi] ? req_wdata_q[gi*8 +: 8]
                                                      : rd_dout[gi*8 +: 8];
    end
  endgenerate

  always_comb begin
    state_d     = state_q;
    mem_ready_d = 1'b0;
    ld_ready_d  = 1'b0;
    mem_rdata_d = mem_rdata_q;
    bus_err_d   = bus_err_q;
    last_ld_d   = last_ld_q;
    req_bank_d  = req_bank_q;
    req_word_d  = req_word_q;
    req_wstrb_d = req_wstrb_q;
    req_wdata_d = req_wdata_q;
    cmd_en      = 1'b0;
    cmd_we      = 1'b0;
    cmd_bank    = 1'b0;
    cmd_addr    = '0;
    cmd_din     = '0;

    case (state_q)
      IDLE: begin
        if (serve_ld) begin
          cmd_en     = 1'b1;
          cmd_we     = 1'b1;
          cmd_bank   = ld_bank;
          cmd_addr   = ld_addr;
          cmd_din    = ld_wdata;
          ld_ready_d = 1'b1;
          last_ld_d  = 1'b1;
          state_d    = LD_ACK;
        end else if (mem_valid) begin
          last_ld_d   = 1'b0;
          req_bank_d  = cpu_bank;
          req_word_d  = cpu_word;
          req_wstrb_d = mem_wstrb;
          req_wdata_d = mem_wdata;
          if (cpu_oor) begin
            mem_rdata_d = '0;
            bus_err_d   = 1'b1;
            mem_ready_d = 1'b1;
            state_d     = RESP;
          end else if (mem_wstrb == {STRB_W{1'b1}}) begin
            cmd_en      = 1'b1;
            cmd_we      = 1'b1;
            cmd_bank    = cpu_bank;
            cmd_addr    = cpu_word;
            cmd_din     = mem_wdata;
            mem_ready_d = 1'b1;
            state_d     = RESP;
          end else begin
            // Plain reads and the read half of a read-modify-write.
            cmd_en   = 1'b1;
            cmd_bank = cpu_bank;
            cmd_addr = cpu_word;
            state_d  = RD_WAIT;
          end
        end
      end
      RD_WAIT: begin
        mem_rdata_d = rd_dout;
        mem_ready_d = 1'b1;
        state_d     = RESP;
        if (req_wstrb_q != '0) begin
          cmd_en   = 1'b1;
          cmd_we   = 1'b1;
          cmd_bank = req_bank_q;
          cmd_addr = req_word_q;
          cmd_din  = merged_data;
        end
      end
      RESP:    state_d = IDLE;
      LD_ACK:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Gating with resetn keeps both macros deselected while reset is asserted,
  // so an interrupted read-modify-write never reaches the array.
  always_comb begin
    imem_csb  = 1'b1;
    imem_web  = 1'b1;
    imem_addr = cmd_addr;
    imem_din  = cmd_din;
    dmem_csb  = 1'b1;
    dmem_web  = 1'b1;
    dmem_addr = cmd_addr;
    dmem_din  = cmd_din;
    if (resetn && cmd_en) begin
      if (cmd_bank) begin
        dmem_csb = 1'b0;
        dmem_web = !cmd_we;
      end else begin
        imem_csb = 1'b0;
        imem_web = !cmd_we;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= IDLE;
      mem_ready_q <= 1'b0;
      ld_ready_q  <= 1'b0;
      mem_rdata_q <= '0;
      bus_err_q   <= 1'b0;
      last_ld_q   <= 1'b0;
      req_bank_q  <= 1'b0;
      req_word_q  <= '0;
      req_wstrb_q <= '0;
      req_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      mem_ready_q <= mem_ready_d;
      ld_ready_q  <= ld_ready_d;
      mem_rdata_q <= mem_rdata_d;
      bus_err_q   <= bus_err_d;
      last_ld_q   <= last_ld_d;
      req_bank_q  <= req_bank_d;
      req_word_q  <= req_word_d;
      req_wstrb_q <= req_wstrb_d;
      req_wdata_q <= req_wdata_d;
    end
  end

  assign mem_ready = mem_ready_q;
  assign mem_rdata = mem_rdata_q;
  assign bus_err   = bus_err_q;

endmodule

// File: tb/tb_sram_mem_ctrl.sv
// Directed bench for sram_mem_ctrl with behavioural models of both SRAM macros.
`timescale 1ns/1ps

module tb_sram_mem_ctrl;
  localparam int DW = 32;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          resetn;
  logic          mem_valid, mem_instr;
  logic [31:0]   mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [3:0]    mem_wstrb;
  logic          mem_ready;
  logic [DW-1:0] mem_rdata;
  logic          ld_valid, ld_bank;
  logic [AW-1:0] ld_addr;
  logic [DW-1:0] ld_wdata;
  logic          ld_ready, bus_err;
  logic          imem_csb, imem_web, dmem_csb, dmem_web;
  logic [AW-1:0] imem_addr, dmem_addr;
  logic [DW-1:0] imem_din, dmem_din, imem_dout, dmem_dout;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [DW-1:0] imem_arr [32];
  logic [DW-1:0] dmem_arr [32];
  int imem_rd_cnt = 0, imem_wr_cnt = 0, dmem_rd_cnt = 0, dmem_wr_cnt = 0;
  int dmem_rd_cyc = 0, dmem_wr_cyc = 0;

  logic [31:0] rd;
  int          lat;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Macro model: command captured at posedge, read data visible until the next posedge.
  always @(posedge clk) begin
    if (!imem_csb) begin
      if (!imem_web) begin imem_arr[imem_addr] <= imem_din; imem_wr_cnt <= imem_wr_cnt + 1; end
      else begin imem_dout <= imem_arr[imem_addr]; imem_rd_cnt <= imem_rd_cnt + 1; end
    end
    if (!dmem_csb) begin
      if (!dmem_web) begin dmem_arr[dmem_addr] <= dmem_din; dmem_wr_cnt <= dmem_wr_cnt + 1; dmem_wr_cyc <= cyc; end
      else begin dmem_dout <= dmem_arr[dmem_addr]; dmem_rd_cnt <= dmem_rd_cnt + 1; dmem_rd_cyc <= cyc; end
    end
  end

  sram_mem_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .resetn(resetn),
    .mem_valid(mem_valid), .mem_instr(mem_instr), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .ld_valid(ld_valid), .ld_bank(ld_bank), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
    .ld_ready(ld_ready), .bus_err(bus_err),
    .imem_csb(imem_csb), .imem_web(imem_web), .imem_addr(imem_addr), .imem_din(imem_din), .imem_dout(imem_dout),
    .dmem_csb(dmem_csb), .dmem_web(dmem_web), .dmem_addr(dmem_addr), .dmem_din(dmem_din), .dmem_dout(dmem_dout)
  );

  // Starts and ends one edge+1ns after a posedge with the controller idle.
  task automatic cpu_xfer(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] wstrb,
                          output logic [31:0] rdata, output int latency);
    mem_valid = 1'b1; mem_addr = addr; mem_wdata = wdata; mem_wstrb = wstrb;
    latency = -1; rdata = 32'h0;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk); #1;
      if (mem_ready) begin latency = n; rdata = mem_rdata; break; end
    end
    mem_valid = 1'b0; mem_wstrb = 4'h0;
    @(posedge clk); #1;
    $display("cpu addr=%h wstrb=%b wdata=%h -> rdata=%h latency=%0d", addr, wstrb, wdata, rdata, latency);
  endtask

  task automatic test_reset();
    resetn = 1'b0; mem_instr = 1'b0;
    mem_valid = 1'b1; mem_addr = 32'h84; mem_wdata = 32'hFFFFFFFF; mem_wstrb = 4'hF;
    ld_valid = 1'b1; ld_bank = 1'b1; ld_addr = 5'd1; ld_wdata = 32'hFFFFFFFF;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (mem_ready !== 1'b0) begin errors++; $display("FAIL reset_mem_ready: got %b expected 0", mem_ready); end
    checks++; if (ld_ready !== 1'b0) begin errors++; $display("FAIL reset_ld_ready: got %b expected 0", ld_ready); end
    checks++; if (mem_rdata !== 32'h0) begin errors++; $display("FAIL reset_mem_rdata: got %h expected 0", mem_rdata); end
    checks++; if (bus_err !== 1'b0) begin errors++; $display("FAIL reset_bus_err: got %b expected 0", bus_err); end
    checks++; if ({imem_csb, imem_web, dmem_csb, dmem_web} !== 4'b1111) begin errors++;
      $display("FAIL reset_sram_cmd: got %b expected 1111", {imem_csb, imem_web, dmem_csb, dmem_web}); end
    checks++; if (imem_wr_cnt + dmem_wr_cnt !== 0) begin errors++;
      $display("FAIL reset_no_write: got %0d writes expected 0", imem_wr_cnt + dmem_wr_cnt); end
    mem_valid = 1'b0; ld_valid = 1'b0; mem_wstrb = 4'h0;
    @(negedge clk); resetn = 1'b1;
    @(posedge clk); #1;
    $display("reset released");
  endtask

  task automatic test_loader();
    int dsum;
`ifdef SRAM_CTRL_LOADER_EN
    ld_valid = 1'b1; ld_bank = 1'b0; ld_addr = 5'd0; ld_wdata = 32'h00000013;
    lat = -1;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk); #1;
      if (ld_ready) begin lat = n; break; end
    end
    ld_valid = 1'b0;
    @(posedge clk); #1;
    $display("loader bank=0 addr=0 wdata=00000013 latency=%0d", lat);
    checks++; if (lat !== 1) begin errors++; $display("FAIL loader_latency: got %0d expected 1", lat); end
    dsum = dmem_rd_cnt + dmem_wr_cnt;
    cpu_xfer(32'h0, 32'h0, 4'h0, rd, lat);
`else
    cpu_xfer(32'h0, 32'h00000013, 4'hF, rd, lat);
    ld_valid = 1'b1; ld_bank = 1'b0; ld_addr = 5'd0; ld_wdata = 32'hFFFFFFFF;
    dsum = dmem_rd_cnt + dmem_wr_cnt;
    cpu_xfer(32'h0, 32'h0, 4'h0, rd, lat);
    checks++; if (ld_ready !== 1'b0) begin errors++; $display("FAIL loader_disabled_ready: got %b expected 0", ld_ready); end
    ld_valid = 1'b0;
`endif
    checks++; if (imem_arr[0] !== 32'h00000013) begin errors++; $display("FAIL imem_word0: got %h expected 00000013", imem_arr[0]); end
    checks++; if (rd !== 32'h00000013) begin errors++; $display("FAIL imem_read_data: got %h expected 00000013", rd); end
    checks++; if (lat !== 2) begin errors++; $display("FAIL imem_read_latency: got %0d expected 2", lat); end
    checks++; if (dmem_rd_cnt + dmem_wr_cnt !== dsum) begin errors++;
      $display("FAIL dmem_untouched: got %0d accesses expected %0d", dmem_rd_cnt + dmem_wr_cnt, dsum); end
  endtask

  task automatic test_full_write();
    cpu_xfer(32'h84, 32'hDEADBEEF, 4'hF, rd, lat);
    checks++; if (lat !== 1) begin errors++; $display("FAIL full_write_latency: got %0d expected 1", lat); end
    checks++; if (dmem_arr[1] !== 32'hDEADBEEF) begin errors++; $display("FAIL full_write_array: got %h expected deadbeef", dmem_arr[1]); end
    cpu_xfer(32'h84, 32'h0, 4'h0, rd, lat);
    checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL full_write_readback: got %h expected deadbeef", rd); end
    checks++; if (lat !== 2) begin errors++; $display("FAIL dmem_read_latency: got %0d expected 2", lat); end
    cpu_xfer(32'h88, 32'h12345678, 4'hF, rd, lat);
    checks++; if (mem_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL rdata_hold: got %h expected deadbeef", mem_rdata); end
  endtask

  task automatic test_partial_write();
    int rc, wc;
    rc = dmem_rd_cnt; wc = dmem_wr_cnt;
    cpu_xfer(32'h84, 32'h0000AA00, 4'b0010, rd, lat);
    checks++; if (lat !== 2) begin errors++; $display("FAIL rmw_latency: got %0d expected 2", lat); end
    checks++; if ((dmem_rd_cnt - rc) !== 1 || (dmem_wr_cnt - wc) !== 1) begin errors++;
      $display("FAIL rmw_access_count: got rd=%0d wr=%0d expected 1 1", dmem_rd_cnt - rc, dmem_wr_cnt - wc); end
    checks++; if (dmem_wr_cyc - dmem_rd_cyc !== 1) begin errors++;
      $display("FAIL rmw_consecutive: got gap %0d expected 1", dmem_wr_cyc - dmem_rd_cyc); end
    cpu_xfer(32'h84, 32'h0, 4'h0, rd, lat);
    checks++; if (rd !== 32'hDEADAAEF) begin errors++; $display("FAIL rmw_byte1: got %h expected deadaaef", rd); end
    cpu_xfer(32'h84, 32'h11223344, 4'b1001, rd, lat);
    cpu_xfer(32'h84, 32'h0, 4'h0, rd, lat);
    checks++; if (rd !== 32'h11ADAA44) begin errors++; $display("FAIL rmw_bytes30: got %h expected 11adaa44", rd); end
    cpu_xfer(32'h0, 32'h00550000, 4'b0100, rd, lat);
    cpu_xfer(32'h0, 32'h0, 4'h0, rd, lat);
    checks++; if (rd !== 32'h00550013) begin errors++; $display("FAIL rmw_imem_byte2: got %h expected 00550013", rd); end
  endtask

  task automatic test_out_of_range();
    int tot;
    tot = imem_rd_cnt + imem_wr_cnt + dmem_rd_cnt + dmem_wr_cnt;
    cpu_xfer(32'h100, 32'h0, 4'h0, rd, lat);
    checks++; if (lat !== 1) begin errors++; $display("FAIL oor_latency: got %0d expected 1", lat); end
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL oor_rdata: got %h expected 0", rd); end
    checks++; if (bus_err !== 1'b1) begin errors++; $display("FAIL oor_bus_err: got %b expected 1", bus_err); end
    cpu_xfer(32'h200, 32'hFFFFFFFF, 4'hF, rd, lat);
    checks++; if (imem_rd_cnt + imem_wr_cnt + dmem_rd_cnt + dmem_wr_cnt !== tot) begin errors++;
      $display("FAIL oor_no_access: got %0d accesses expected %0d", imem_rd_cnt + imem_wr_cnt + dmem_rd_cnt + dmem_wr_cnt, tot); end
    cpu_xfer(32'h87, 32'h0, 4'h0, rd, lat);
    checks++; if (rd !== 32'h11ADAA44) begin errors++; $display("FAIL low_bits_ignored: got %h expected 11adaa44", rd); end
    checks++; if (bus_err !== 1'b1) begin errors++; $display("FAIL bus_err_sticky: got %b expected 1", bus_err); end
  endtask

  task automatic test_back_to_back();
    int ev_cyc [8];
    logic ev_ld [8];
    int nev;
    int exp_n;
    @(negedge clk); resetn = 1'b0;
    @(negedge clk); resetn = 1'b1;
    @(posedge clk); #1;
    checks++; if (bus_err !== 1'b0) begin errors++; $display("FAIL bus_err_cleared: got %b expected 0", bus_err); end
    ld_valid = 1'b1; ld_bank = 1'b0; ld_addr = 5'd5; ld_wdata = 32'hCAFE0005;
    mem_valid = 1'b1; mem_addr = 32'h84; mem_wstrb = 4'h0; mem_wdata = 32'h0;
    nev = 0;
    for (int n = 1; n <= 9; n++) begin
      @(posedge clk); #1;
      if (ld_ready && nev < 8) begin ev_ld[nev] = 1'b1; ev_cyc[nev] = n; nev++; $display("grant loader at edge %0d", n); end
      if (mem_ready && nev < 8) begin ev_ld[nev] = 1'b0; ev_cyc[nev] = n; nev++; $display("grant cpu at edge %0d rdata=%h", n, mem_rdata); end
    end
    ld_valid = 1'b0; mem_valid = 1'b0;
    @(posedge clk); #1;
`ifdef SRAM_CTRL_LOADER_EN
    exp_n = 4;
    checks++; if (nev !== exp_n) begin errors++; $display("FAIL arb_event_count: got %0d expected %0d", nev, exp_n); end
    if (nev >= 4) begin
      checks++; if ({ev_ld[0], ev_ld[1], ev_ld[2], ev_ld[3]} !== 4'b1010) begin errors++;
        $display("FAIL arb_order: got %b expected 1010", {ev_ld[0], ev_ld[1], ev_ld[2], ev_ld[3]}); end
      checks++; if (ev_cyc[0] !== 1 || ev_cyc[1] !== 4 || ev_cyc[2] !== 6 || ev_cyc[3] !== 9) begin errors++;
        $display("FAIL arb_timing: got %0d %0d %0d %0d expected 1 4 6 9", ev_cyc[0], ev_cyc[1], ev_cyc[2], ev_cyc[3]); end
    end
    checks++; if (imem_arr[5] !== 32'hCAFE0005) begin errors++; $display("FAIL arb_loader_data: got %h expected cafe0005", imem_arr[5]); end
`else
    exp_n = 3;
    checks++; if (nev !== exp_n) begin errors++; $display("FAIL arb_event_count: got %0d expected %0d", nev, exp_n); end
    if (nev >= 3) begin
      checks++; if ({ev_ld[0], ev_ld[1], ev_ld[2]} !== 3'b000) begin errors++;
        $display("FAIL arb_cpu_only: got %b expected 000", {ev_ld[0], ev_ld[1], ev_ld[2]}); end
      checks++; if (ev_cyc[0] !== 2 || ev_cyc[1] !== 5 || ev_cyc[2] !== 8) begin errors++;
        $display("FAIL arb_timing: got %0d %0d %0d expected 2 5 8", ev_cyc[0], ev_cyc[1], ev_cyc[2]); end
    end
`endif
    checks++; if (mem_rdata !== 32'h11ADAA44) begin errors++; $display("FAIL arb_cpu_data: got %h expected 11adaa44", mem_rdata); end
  endtask

  task automatic test_reset_rmw();
    int wc;
    mem_valid = 1'b1; mem_addr = 32'h84; mem_wdata = 32'h0000BB00; mem_wstrb = 4'b0010;
    @(posedge clk); #1;
    checks++; if ({dmem_csb, dmem_web} !== 2'b00) begin errors++;
      $display("FAIL rmw_write_phase: got csb/web %b expected 00", {dmem_csb, dmem_web}); end
    #1 resetn = 1'b0;
    #1;
    checks++; if ({imem_csb, dmem_csb, dmem_web} !== 3'b111) begin errors++;
      $display("FAIL rst_mid_cmd: got %b expected 111", {imem_csb, dmem_csb, dmem_web}); end
    checks++; if (mem_ready !== 1'b0 || mem_rdata !== 32'h0) begin errors++;
      $display("FAIL rst_mid_outputs: got ready=%b rdata=%h expected 0 0", mem_ready, mem_rdata); end
    wc = dmem_wr_cnt;
    @(posedge clk); #1;
    checks++; if (dmem_wr_cnt !== wc) begin errors++; $display("FAIL rst_mid_no_write: got %0d writes expected %0d", dmem_wr_cnt, wc); end
    mem_valid = 1'b0; mem_wstrb = 4'h0;
    @(negedge clk); resetn = 1'b1;
    @(posedge clk); #1;
    cpu_xfer(32'h84, 32'h0, 4'h0, rd, lat);
    checks++; if (lat !== 2) begin errors++; $display("FAIL rst_idle_latency: got %0d expected 2", lat); end
    checks++; if (rd !== 32'h11ADAA44 && rd !== 32'h11ADBB44) begin errors++;
      $display("FAIL rst_word_intact: got %h expected 11adaa44 or 11adbb44", rd); end
  endtask

  initial begin
    test_reset();
    test_loader();
    test_full_write();
    test_partial_write();
    test_out_of_range();
    test_back_to_back();
    test_reset_rmw();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
